// File: rtl/log_lut_stream_loader_if.sv
// Stream-in and LUT-write-out signal bundle for the log LUT loader.
// slave is the loader's view; master is the host/consumer side.
interface log_lut_stream_loader_if #(
    parameter int unsigned FLOAT_LEN = 16
);
    logic                 s_valid;
    logic                 s_ready;
    logic [FLOAT_LEN-1:0] s_data;
    logic                 s_last;

    logic                 lut_wr_en;
    logic [FLOAT_LEN-1:0] log2_lut_data_in0;
    logic [FLOAT_LEN-1:0] log2_lut_data_in1;
    logic [FLOAT_LEN-1:0] exp2_lut_data_in;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready,
        input  lut_wr_en,
        input  log2_lut_data_in0,
        input  log2_lut_data_in1,
        input  exp2_lut_data_in
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready,
        output lut_wr_en,
        output log2_lut_data_in0,
        output log2_lut_data_in1,
        output exp2_lut_data_in
    );
endinterface

// File: rtl/log_lut_stream_loader.sv
// Packs a host word stream into {log2 t0, log2 t1, exp2} triplets and writes them
// sequentially into the log-domain unit's LUTs, one write pulse per triplet.
module log_lut_stream_loader #(
    parameter int unsigned FLOAT_LEN = 16,
    parameter int unsigned LUT_SIZE  = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    log_lut_stream_loader_if.slave    bus,
    output logic                      busy,
    output logic                      load_done,
    output logic                      load_err,
    output logic [$clog2(LUT_SIZE):0] wr_count
);
    localparam int unsigned CntW = $clog2(LUT_SIZE) + 1;

    typedef enum logic [2:0] {StIdle, StLoad, StFlush, StDone, StErr} state_e;

    state_e               state_q, state_d;
    logic [1:0]           phase_q, phase_d;
    logic [FLOAT_LEN-1:0] stage0_q, stage0_d;
    logic [FLOAT_LEN-1:0] stage1_q, stage1_d;
    logic [FLOAT_LEN-1:0] data0_q, data0_d;
    logic [FLOAT_LEN-1:0] data1_q, data1_d;
    logic [FLOAT_LEN-1:0] data2_q, data2_d;
    logic                 wr_en_q, wr_en_d;
    logic [CntW-1:0]      wr_count_q, wr_count_d;
    logic                 last_q, last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            stage0_q   <= '0;
            stage1_q   <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            data2_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_count_q <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            stage0_q   <= stage0_d;
            stage1_q   <= stage1_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            wr_en_q    <= wr_en_d;
            wr_count_q <= wr_count_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        stage0_d   = stage0_q;
        stage1_d   = stage1_q;
        data0_d    = data0_q;
        data1_d    = data1_q;
        data2_d    = data2_q;
        wr_en_d    = 1'b0;
        wr_count_d = wr_count_q;
        last_d     = last_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StLoad;
                    phase_d    = '0;
                    wr_count_d = '0;
                end
            end
            StLoad: begin
                if (bus.s_valid) begin
                    case (phase_q)
                        2'd0: begin
                            stage0_d = bus.s_data;
                            phase_d  = 2'd1;
                        end
                        2'd1: begin
                            stage1_d = bus.s_data;
                            phase_d  = 2'd2;
                        end
                        default: begin
                            data0_d    = stage0_q;
                            data1_d    = stage1_q;
                            data2_d    = bus.s_data;
                            wr_en_d    = 1'b1;
                            wr_count_d = wr_count_q + CntW'(1);
                            phase_d    = 2'd0;
                        end
                    endcase
                    // The final triplet goes through FLUSH so its pulse lands before DONE/ERR.
                    if (phase_q == 2'd2 && wr_count_q == CntW'(LUT_SIZE - 1)) begin
                        state_d = StFlush;
                        last_d  = bus.s_last;
                    end else if (bus.s_last) begin
                        state_d = StErr;
                    end
                end
            end
            StFlush: state_d = last_q ? StDone : StErr;
            default: state_d = StIdle;
        endcase
    end

    assign bus.s_ready           = (state_q == StLoad);
    assign bus.lut_wr_en         = wr_en_q;
    assign bus.log2_lut_data_in0 = data0_q;
    assign bus.log2_lut_data_in1 = data1_q;
    assign bus.exp2_lut_data_in  = data2_q;

    assign busy      = (state_q == StLoad) || (state_q == StFlush);
    assign load_done = (state_q == StDone);
    assign load_err  = (state_q == StErr);
    assign wr_count  = wr_count_q;
endmodule

// File: tb/tb_log_lut_stream_loader.sv
// Directed/randomized bench for log_lut_stream_loader with a triplet-level reference model.
module tb_log_lut_stream_loader;
    localparam int unsigned FL = 16;
    localparam int unsigned LS = 128;
    localparam int          NW = 3 * LS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 busy, load_done, load_err;
    logic [$clog2(LS):0]  wr_count;

    log_lut_stream_loader_if #(.FLOAT_LEN(FL)) bus ();

    log_lut_stream_loader #(.FLOAT_LEN(FL), .LUT_SIZE(LS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .load_done (load_done),
        .load_err  (load_err),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_w[NW];
    int acc_cyc[NW];
    int p_d0[$], p_d1[$], p_e2[$], p_cyc[$];
    logic [FL-1:0] hold0, hold1, hold2;
    logic          prev_en;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Consumer model: logs every write pulse, checks width and output hold between pulses.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0   <= '0;
            hold1   <= '0;
            hold2   <= '0;
            prev_en <= 1'b0;
        end else begin
            if (bus.lut_wr_en) begin
                check("pulse_width", {63'd0, prev_en}, 64'd0);
                p_d0.push_back(int'(bus.log2_lut_data_in0));
                p_d1.push_back(int'(bus.log2_lut_data_in1));
                p_e2.push_back(int'(bus.exp2_lut_data_in));
                p_cyc.push_back(cyc);
                hold0 <= bus.log2_lut_data_in0;
                hold1 <= bus.log2_lut_data_in1;
                hold2 <= bus.exp2_lut_data_in;
            end else begin
                check("data_hold",
                      {16'd0, bus.log2_lut_data_in0, bus.log2_lut_data_in1, bus.exp2_lut_data_in},
                      {16'd0, hold0, hold1, hold2});
            end
            prev_en <= bus.lut_wr_en;
        end
    end

    task automatic run_load(input int n, input int last_idx, input bit gaps, input int base,
                            input int start_at);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        for (int i = 0; i < NW; i++) exp_w[i] = (base + i) & 32'hFFFF;
        p_d0.delete();
        p_d1.delete();
        p_e2.delete();
        p_cyc.delete();
        start = 1'b1;
        @(negedge clk);
        check("ready_before_start", {63'd0, bus.s_ready}, 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("count_cleared", 64'(wr_count), 64'd0);
        check("busy_at_load", {63'd0, busy}, 64'd1);
        check("done_cleared", {63'd0, load_done}, 64'd0);
        check("err_cleared", {63'd0, load_err}, 64'd0);
        while (idx < n && guard < 4000) begin
            bus.s_data  = exp_w[idx][FL-1:0];
            bus.s_last  = (idx == last_idx);
            bus.s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            start       = (idx == start_at);
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        start       = 1'b0;
        check("words_accepted", 64'(idx), 64'(n));
    endtask

    function automatic int exp_pulses(input int n);
        return (n / 3 > LS) ? LS : n / 3;
    endfunction

    task automatic check_pulses(input int n_exp);
        int m;
        check("pulse_count", 64'(p_d0.size()), 64'(n_exp));
        m = (p_d0.size() < n_exp) ? p_d0.size() : n_exp;
        for (int k = 0; k < m; k++) begin
            check("pulse_data0", 64'(p_d0[k]), 64'(exp_w[3*k]));
            check("pulse_data1", 64'(p_d1[k]), 64'(exp_w[3*k+1]));
            check("pulse_exp2", 64'(p_e2[k]), 64'(exp_w[3*k+2]));
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_ready", {63'd0, bus.s_ready}, 64'd0);
        check("rst_wr_en", {63'd0, bus.lut_wr_en}, 64'd0);
        check("rst_data0", 64'(bus.log2_lut_data_in0), 64'd0);
        check("rst_data1", 64'(bus.log2_lut_data_in1), 64'd0);
        check("rst_exp2", 64'(bus.exp2_lut_data_in), 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, load_done}, 64'd0);
        check("rst_err", {63'd0, load_err}, 64'd0);
        check("rst_count", 64'(wr_count), 64'd0);

        // s_valid while idle consumes nothing
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h1234;
        repeat (5) @(posedge clk);
        #1;
        check("idle_count", 64'(wr_count), 64'd0);
        check("idle_pulses", 64'(p_d0.size()), 64'd0);
        check("idle_ready", {63'd0, bus.s_ready}, 64'd0);
        bus.s_valid = 1'b0;

        // Continuous load with exact timing
        run_load(NW, NW - 1, 1'b0, 0, -1);
        @(negedge clk);
        check("final_pulse", {63'd0, bus.lut_wr_en}, 64'd1);
        check("flush_busy", {63'd0, busy}, 64'd1);
        check("flush_not_done", {63'd0, load_done}, 64'd0);
        @(negedge clk);
        check("cont_done", {63'd0, load_done}, 64'd1);
        check("cont_err", {63'd0, load_err}, 64'd0);
        check("cont_busy", {63'd0, busy}, 64'd0);
        check("cont_wr_en", {63'd0, bus.lut_wr_en}, 64'd0);
        check("cont_ready", {63'd0, bus.s_ready}, 64'd0);
        check("cont_count", 64'(wr_count), 64'(LS));
        check_pulses(LS);
        for (int k = 0; k < p_cyc.size() && k < LS; k++)
            check("pulse_timing", 64'(p_cyc[k]), 64'(acc_cyc[3*k+2] + 1));
        @(posedge clk);
        #1;

        // Randomized gaps on s_valid
        run_load(NW, NW - 1, 1'b1, 1000, -1);
        settle();
        check("gap_done", {63'd0, load_done}, 64'd1);
        check("gap_count", 64'(wr_count), 64'(LS));
        check_pulses(exp_pulses(NW));

        // Early s_last on word 99
        run_load(100, 99, 1'b0, 5000, -1);
        settle();
        check("early_err", {63'd0, load_err}, 64'd1);
        check("early_done", {63'd0, load_done}, 64'd0);
        check("early_count", 64'(wr_count), 64'd33);
        check("early_ready", {63'd0, bus.s_ready}, 64'd0);
        check("early_busy", {63'd0, busy}, 64'd0);
        check_pulses(exp_pulses(100));

        // Missing s_last
        run_load(NW, -1, 1'b0, 7000, -1);
        settle();
        check("miss_err", {63'd0, load_err}, 64'd1);
        check("miss_done", {63'd0, load_done}, 64'd0);
        check("miss_count", 64'(wr_count), 64'(LS));
        check_pulses(exp_pulses(NW));

        // start mid-load is ignored, then reset aborts the load
        run_load(200, -1, 1'b0, 11000, 50);
        @(negedge clk);
        check("ctl_busy", {63'd0, busy}, 64'd1);
        check("ctl_count", 64'(wr_count), 64'd66);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", {63'd0, bus.s_ready}, 64'd0);
        check("abort_wr_en", {63'd0, bus.lut_wr_en}, 64'd0);
        check("abort_data",
              {16'd0, bus.log2_lut_data_in0, bus.log2_lut_data_in1, bus.exp2_lut_data_in},
              64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, load_done}, 64'd0);
        check("abort_err", {63'd0, load_err}, 64'd0);
        check("abort_count", 64'(wr_count), 64'd0);
        check_pulses(exp_pulses(200));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_load(NW, NW - 1, 1'b0, 13000, -1);
        settle();
        check("post_abort_done", {63'd0, load_done}, 64'd1);
        check("post_abort_count", 64'(wr_count), 64'(LS));
        check_pulses(exp_pulses(NW));

        // Reload after DONE with new data
        run_load(NW, NW - 1, 1'b0, 30000, -1);
        settle();
        check("reload_done", {63'd0, load_done}, 64'd1);
        check("reload_err", {63'd0, load_err}, 64'd0);
        check("reload_count", 64'(wr_count), 64'(LS));
        check_pulses(exp_pulses(NW));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
